// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
//   sz_e        : dataSize encodings (2'b10 is treated as a word)
//   sb_entry_t  : one buffered store {word addr, lane data, byte enables}
//   lane_t      : lane-positioned data plus byte enables
//   laneAlign() : (size, addr[1:0], right-aligned data) -> lane_t, big-endian
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b11
  } sz_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } lane_t;

  // Big-endian: byte offset 0 is bits [31:24], be[3] covers [31:24].
  function automatic lane_t laneAlign(input logic [1:0] size, input logic [1:0] off,
                                      input logic [31:0] d);
    lane_t r;
    r.data = '0;
    r.be   = '0;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0: begin r.data = {d[7:0], 24'h0};        r.be = 4'b1000; end
          2'd1: begin r.data = {8'h0, d[7:0], 16'h0};  r.be = 4'b0100; end
          2'd2: begin r.data = {16'h0, d[7:0], 8'h0};  r.be = 4'b0010; end
          default: begin r.data = {24'h0, d[7:0]};     r.be = 4'b0001; end
        endcase
      end
      SZ_HALF: begin
        // off[0] is deliberately ignored for halves.
        if (off[1]) begin r.data = {16'h0, d[15:0]}; r.be = 4'b0011; end
        else        begin r.data = {d[15:0], 16'h0}; r.be = 4'b1100; end
      end
      default: begin r.data = d; r.be = 4'b1111; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Combinational size/offset-to-lane shifter and byte-enable generator.
//   dataSize : access size encoding
//   offset   : byte address bits [1:0]
//   dataIn   : right-aligned store data
//   laneData : data moved into its big-endian lanes, unused lanes zero
//   laneBe   : byte enables, bit 3 = bits [31:24]
module sb_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  dataSize,
  input  logic [1:0]  offset,
  input  logic [31:0] dataIn,
  output logic [31:0] laneData,
  output logic [3:0]  laneBe
);

  lane_t lane;

  assign lane     = laneAlign(dataSize, offset, dataIn);
  assign laneData = lane.data;
  assign laneBe   = lane.be;

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between MEM-stage stores and the slow external memory bus.
// Stores are queued in a circular FIFO and drained via ext_wr_req/ext_wr_ack;
// loads read ext_rdata and merge pending buffered bytes combinationally.
//   clk, reset                : clock, synchronous active-high reset
//   aluResultMem, busBMem2    : byte address and right-aligned store data
//   memWr, dataSize           : store strobe and access size
//   unshiftedMemDataUnsigned  : merged word-aligned load data
//   ext_raddr, ext_rdata      : external combinational read port
//   ext_wr_req/waddr/wdata/wbe, ext_wr_ack : head-entry write handshake
//   buf_full, buf_empty, overflow : occupancy status, sticky drop flag
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluResultMem,
  input  logic [31:0] busBMem2,
  input  logic        memWr,
  input  logic [1:0]  dataSize,
  output logic [31:0] unshiftedMemDataUnsigned,
  output logic [29:0] ext_raddr,
  input  logic [31:0] ext_rdata,
  output logic        ext_wr_req,
  output logic [29:0] ext_waddr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wbe,
  input  logic        ext_wr_ack,
  output logic        buf_full,
  output logic        buf_empty,
  output logic        overflow
);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             enq, deq;
  logic [31:0]      laneData;
  logic [3:0]       laneBe;
  sb_entry_t        newEntry;

  sb_lane_align uAlign (
    .dataSize (dataSize),
    .offset   (aluResultMem[1:0]),
    .dataIn   (busBMem2),
    .laneData (laneData),
    .laneBe   (laneBe)
  );

  assign newEntry  = '{addr: aluResultMem[31:2], data: laneData, be: laneBe};
  assign buf_full  = (count == (PTR_W+1)'(DEPTH));
  assign buf_empty = (count == '0);

  // At full, an ack in the same cycle frees the head slot, so the store fits.
  assign enq = memWr && (!buf_full || ext_wr_ack);
  assign deq = ext_wr_req && ext_wr_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (memWr && buf_full && !ext_wr_ack) overflow <= 1'b1;
    end
  end

  // Storage is not cleared on reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (enq && !reset) entries[tail] <= newEntry;
  end

  // Head fields are gated so they read 0 (never stale/X) when nothing is pending.
  assign ext_wr_req = !buf_empty;
  assign ext_waddr  = ext_wr_req ? entries[head].addr : '0;
  assign ext_wdata  = ext_wr_req ? entries[head].data : '0;
  assign ext_wbe    = ext_wr_req ? entries[head].be   : '0;
  assign ext_raddr  = aluResultMem[31:2];

  // Oldest-to-youngest overlay, so later stores overwrite earlier bytes.
  logic [PTR_W-1:0] idx;
  always_comb begin
    unshiftedMemDataUnsigned = ext_rdata;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (entries[idx].addr == aluResultMem[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b])
            unshiftedMemDataUnsigned[b*8 +: 8] = entries[idx].data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluResultMem, busBMem2, ext_rdata;
  logic        memWr, ext_wr_ack;
  logic [1:0]  dataSize;
  logic [31:0] unshiftedMemDataUnsigned, ext_wdata;
  logic [29:0] ext_raddr, ext_waddr;
  logic        ext_wr_req, buf_full, buf_empty, overflow;
  logic [3:0]  ext_wbe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .aluResultMem(aluResultMem), .busBMem2(busBMem2),
    .memWr(memWr), .dataSize(dataSize),
    .unshiftedMemDataUnsigned(unshiftedMemDataUnsigned), .ext_raddr(ext_raddr),
    .ext_rdata(ext_rdata), .ext_wr_req(ext_wr_req), .ext_waddr(ext_waddr),
    .ext_wdata(ext_wdata), .ext_wbe(ext_wbe), .ext_wr_ack(ext_wr_ack),
    .buf_full(buf_full), .buf_empty(buf_empty), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    aluResultMem = a;
    busBMem2     = d;
    dataSize     = sz;
    memWr        = 1'b1;
  endtask

  task automatic doReset();
    memWr = 1'b0; ext_wr_ack = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    aluResultMem = '0; busBMem2 = '0; dataSize = 2'b11; ext_rdata = 32'h0;
    memWr = 1'b0; ext_wr_ack = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", buf_empty); end
    checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", buf_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (ext_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ext_wr_req); end
    checks++; if ({ext_waddr, ext_wdata, ext_wbe} !== 66'h0) begin errors++;
      $display("FAIL reset_head got %h %h %h exp 0", ext_waddr, ext_wdata, ext_wbe); end
  endtask

  task automatic test_byte_merge();
    doReset();
    ext_rdata = 32'h11223344;
    store(32'h101, 32'hAB, 2'b00);
    tick();
    memWr = 1'b0; aluResultMem = 32'h100;
    #1;
    checks++; if (unshiftedMemDataUnsigned !== 32'h11AB3344) begin errors++;
      $display("FAIL t1_merge got %h exp 11ab3344", unshiftedMemDataUnsigned); end
    checks++; if (ext_wbe !== 4'b0100) begin errors++; $display("FAIL t1_wbe got %b exp 0100", ext_wbe); end
    checks++; if (ext_wdata !== 32'h00AB0000) begin errors++; $display("FAIL t1_wdata got %h exp 00ab0000", ext_wdata); end
    checks++; if (ext_waddr !== 30'h40 || ext_raddr !== 30'h40) begin errors++;
      $display("FAIL t1_addr got %h/%h exp 40", ext_waddr, ext_raddr); end
    checks++; if (ext_wr_req !== 1'b1) begin errors++; $display("FAIL t1_req got %b exp 1", ext_wr_req); end
  endtask

  task automatic test_lanes();
    logic [1:0]  sz [6]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic [1:0]  off [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1};
    logic [31:0] din [6] = '{32'hCD, 32'hCD, 32'hCD, 32'h1234, 32'h1234, 32'hCAFEF00D};
    logic [31:0] expD [6] = '{32'hCD000000, 32'h0000CD00, 32'h000000CD, 32'h12340000, 32'h00001234, 32'hCAFEF00D};
    logic [3:0]  expB [6] = '{4'b1000, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111};
    doReset();
    for (int i = 0; i < 6; i++) begin
      store(32'h700 + {30'h0, off[i]}, din[i], sz[i]);
      tick();
      memWr = 1'b0;
      #1;
      checks++; if (ext_wdata !== expD[i] || ext_wbe !== expB[i]) begin errors++;
        $display("FAIL lane%0d got %h/%b exp %h/%b", i, ext_wdata, ext_wbe, expD[i], expB[i]); end
      ext_wr_ack = 1'b1;
      tick();
      ext_wr_ack = 1'b0;
    end
  endtask

  task automatic test_youngest_wins();
    doReset();
    ext_rdata = 32'h0;
    store(32'h200, 32'hDEADBEEF, 2'b11); tick();
    store(32'h202, 32'h1234, 2'b01);     tick();
    memWr = 1'b0; aluResultMem = 32'h200;
    #1;
    checks++; if (unshiftedMemDataUnsigned !== 32'hDEAD1234) begin errors++;
      $display("FAIL t2_merge got %h exp dead1234", unshiftedMemDataUnsigned); end
    checks++; if (ext_wbe !== 4'b1111 || ext_wdata !== 32'hDEADBEEF || ext_waddr !== 30'h80) begin errors++;
      $display("FAIL t2_first got %h %h %b exp 80 deadbeef 1111", ext_waddr, ext_wdata, ext_wbe); end
    ext_wr_ack = 1'b1;
    #1;
    // entry being dequeued still takes part in the merge
    checks++; if (unshiftedMemDataUnsigned !== 32'hDEAD1234) begin errors++;
      $display("FAIL t2_merge_deq got %h exp dead1234", unshiftedMemDataUnsigned); end
    tick();
    checks++; if (ext_wbe !== 4'b0011 || ext_wdata !== 32'h00001234 || ext_waddr !== 30'h80) begin errors++;
      $display("FAIL t2_second got %h %h %b exp 80 00001234 0011", ext_waddr, ext_wdata, ext_wbe); end
    tick();
    ext_wr_ack = 1'b0;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL t2_empty got %b exp 1", buf_empty); end
    checks++; if (unshiftedMemDataUnsigned !== 32'h0) begin errors++;
      $display("FAIL t2_raw got %h exp 0", unshiftedMemDataUnsigned); end
  endtask

  task automatic test_fill_drop();
    doReset();
    for (int i = 0; i < 4; i++) begin
      store(32'h300 + 32'(i*4), 32'(i), 2'b11);
      tick();
    end
    memWr = 1'b0;
    #1;
    checks++; if (buf_full !== 1'b1 || overflow !== 1'b0) begin errors++;
      $display("FAIL t3_full got full=%b ovf=%b exp 1/0", buf_full, overflow); end
    store(32'h310, 32'd4, 2'b11); tick();
    memWr = 1'b0;
    #1;
    checks++; if (overflow !== 1'b1 || buf_full !== 1'b1) begin errors++;
      $display("FAIL t3_drop got ovf=%b full=%b exp 1/1", overflow, buf_full); end
    store(32'h314, 32'd5, 2'b11); ext_wr_ack = 1'b1; tick();
    memWr = 1'b0; ext_wr_ack = 1'b0;
    #1;
    checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL t3_fullacc got %b exp 1", buf_full); end
    // remaining contents must be stores 1,2,3 then 5
    ext_wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] k;
      k = (i == 3) ? 32'd5 : 32'(i + 1);
      #1;
      checks++; if (ext_wr_req !== 1'b1 || ext_waddr !== 30'hC0 + k[29:0] || ext_wdata !== k) begin errors++;
        $display("FAIL t3_drain%0d got %b %h %h exp 1 %h %h", i, ext_wr_req, ext_waddr, ext_wdata, 30'hC0 + k[29:0], k); end
      tick();
    end
    ext_wr_ack = 1'b0;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL t3_empty got %b exp 1", buf_empty); end
  endtask

  task automatic test_wrap();
    logic [61:0] q[$];
    logic [61:0] e;
    doReset();
    for (int k = 0; k < 10; k++) begin
      store(32'h400 + 32'(k*4), 32'hA0000000 + 32'(k), 2'b11);
      ext_wr_ack = (k % 3 != 0);
      #1;
      checks++; if (ext_wr_req !== (q.size() != 0)) begin errors++;
        $display("FAIL t4_req%0d got %b exp %b", k, ext_wr_req, q.size() != 0); end
      if (q.size() != 0 && ext_wr_ack) begin
        e = q.pop_front();
        checks++; if ({ext_waddr, ext_wdata} !== e) begin errors++;
          $display("FAIL t4_order%0d got %h %h exp %h %h", k, ext_waddr, ext_wdata, e[61:32], e[31:0]); end
      end
      if (q.size() < 4 || ext_wr_ack) q.push_back({aluResultMem[31:2], busBMem2});
      tick();
    end
    memWr = 1'b0; ext_wr_ack = 1'b1;
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      #1;
      e = q.pop_front();
      checks++; if (ext_wr_req !== 1'b1 || {ext_waddr, ext_wdata} !== e) begin errors++;
        $display("FAIL t4_drain got %b %h %h exp 1 %h %h", ext_wr_req, ext_waddr, ext_wdata, e[61:32], e[31:0]); end
      tick();
    end
    ext_wr_ack = 1'b0;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL t4_empty got %b exp 1", buf_empty); end
  endtask

  task automatic test_hold();
    doReset();
    store(32'h502, 32'hBEEF, 2'b01); tick();
    memWr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ext_wr_req !== 1'b1 || ext_waddr !== 30'h140 || ext_wdata !== 32'h0000BEEF || ext_wbe !== 4'b0011) begin
        errors++;
        $display("FAIL t5_hold%0d got %b %h %h %b exp 1 140 0000beef 0011", c, ext_wr_req, ext_waddr, ext_wdata, ext_wbe); end
      tick();
    end
    ext_wr_ack = 1'b1; tick();
    ext_wr_ack = 1'b0;
    checks++; if (ext_wr_req !== 1'b0) begin errors++; $display("FAIL t5_clear got %b exp 0", ext_wr_req); end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 5; i++) begin
      store(32'h800 + 32'(i*4), 32'hF0 + 32'(i), 2'b11);
      tick();
    end
    memWr = 1'b0; ext_wr_ack = 1'b1; tick();
    ext_wr_ack = 1'b0;
    checks++; if (overflow !== 1'b1 || buf_full !== 1'b0 || buf_empty !== 1'b0) begin errors++;
      $display("FAIL t6_pre got ovf=%b full=%b empty=%b exp 1/0/0", overflow, buf_full, buf_empty); end
    // store presented during reset must be ignored
    store(32'h804, 32'h77, 2'b11); reset = 1'b1; tick();
    reset = 1'b0; memWr = 1'b0;
    aluResultMem = 32'h804; ext_rdata = 32'h55AA55AA;
    #1;
    checks++; if (buf_empty !== 1'b1 || overflow !== 1'b0 || ext_wr_req !== 1'b0) begin errors++;
      $display("FAIL t6_state got empty=%b ovf=%b req=%b exp 1/0/0", buf_empty, overflow, ext_wr_req); end
    checks++; if (unshiftedMemDataUnsigned !== 32'h55AA55AA) begin errors++;
      $display("FAIL t6_raw got %h exp 55aa55aa", unshiftedMemDataUnsigned); end
  endtask

  initial begin
    test_reset();
    test_byte_merge();
    test_lanes();
    test_youngest_wins();
    test_fill_drop();
    test_wrap();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
